write_ptr_ctrl: RTL and testbench

//  Write-side pointer/flag controller for the async FIFO, replacing the basic write pointer.

---
 rtl/write_ptr_ctrl.sv | 104 ++++++++++
 tb/tb_write_ptr_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/write_ptr_ctrl.sv
// Write-side pointer/flag controller for the async FIFO: binary/Gray write pointer, RAM address,
// registered full/almost-full/level and sticky overflow. Optional macro: WRITE_PTR_CTRL_SYNC_EN.
module write_ptr_ctrl #(
  parameter int ADDR_SIZE = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_SIZE:0]   wr_ptr_2_i,
  input  logic                 inc_i,
  input  logic [ADDR_SIZE:0]   afull_thresh_i,
  input  logic                 clr_ovf_i,
  output logic [ADDR_SIZE:0]   ptr_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic                 wr_en_o,
  output logic                 fifo_full_o,
  output logic                 almost_full_o,
  output logic [ADDR_SIZE:0]   level_o,
  output logic                 overflow_o
);

  localparam int A = ADDR_SIZE;

  logic [A:0] rptr_g;
  logic [A:0] rbin;
  logic [A:0] full_cmp;
  logic [A:0] wbin_q, wbin_d;
  logic [A:0] wgray_q, wgray_d;
  logic [A:0] level_q, level_d;
  logic       full_q, full_d;
  logic       afull_q, afull_d;
  logic       ovf_q, ovf_d;

`ifdef WRITE_PTR_CTRL_SYNC_EN
  // Two-flop synchroniser on the incoming read pointer.
  logic [A:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= wr_ptr_2_i;
      sync2_q <= sync1_q;
    end
  end

  assign rptr_g = sync2_q;
`else
  assign rptr_g = wr_ptr_2_i;
`endif

  function automatic logic [A:0] gray2bin(input logic [A:0] g);
    logic [A:0] b;
    b[A] = g[A];
    for (int i = A - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Flags are computed from the post-write pointer so full blocks the very next request.
  always_comb begin
    rbin     = gray2bin(rptr_g);
    wr_en_o  = inc_i & ~full_q & rst_i;
    wbin_d   = wbin_q + {{A{1'b0}}, wr_en_o};
    wgray_d  = wbin_d ^ (wbin_d >> 1);
    full_cmp = {~rptr_g[A:A-1], rptr_g[A-2:0]};
    full_d   = (wgray_d == full_cmp);
    level_d  = wbin_d - rbin;
    afull_d  = (afull_thresh_i != '0) && (level_d >= afull_thresh_i);
    ovf_d    = ovf_q;
    if (inc_i && full_q) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ptr_o         = wgray_q;
  assign addr_o        = wbin_q[A-1:0];
  assign fifo_full_o   = full_q;
  assign almost_full_o = afull_q;
  assign level_o       = level_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_write_ptr_ctrl.sv
// Bench for write_ptr_ctrl (ADDR_SIZE=3): word-count reference model, directed and random scenarios.
module tb_write_ptr_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] wr_ptr_2_i = '0;
  logic       inc_i = 1'b0;
  logic [3:0] afull_thresh_i = '0;
  logic       clr_ovf_i = 1'b0;
  logic [3:0] ptr_o;
  logic [2:0] addr_o;
  logic       wr_en_o;
  logic       fifo_full_o;
  logic       almost_full_o;
  logic [3:0] level_o;
  logic       overflow_o;

  write_ptr_ctrl #(.ADDR_SIZE(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_ptr_2_i(wr_ptr_2_i), .inc_i(inc_i),
    .afull_thresh_i(afull_thresh_i), .clr_ovf_i(clr_ovf_i), .ptr_o(ptr_o),
    .addr_o(addr_o), .wr_en_o(wr_en_o), .fifo_full_o(fifo_full_o),
    .almost_full_o(almost_full_o), .level_o(level_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: absolute counts of words written and read.
  int   m_w, rcnt, m_level, m_s1, m_s2;
  logic m_full, m_afull, m_ovf;

  function automatic logic [3:0] gray4(input int x);
    logic [3:0] b;
    b = 4'(x & 15);
    return b ^ (b >> 1);
  endfunction

  task automatic model_zero();
    m_w = 0; rcnt = 0; m_level = 0; m_s1 = 0; m_s2 = 0;
    m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0;
  endtask

  // Advance one clock edge, updating the model from the inputs applied before it.
  task automatic step();
    int   nw, rseen, lvl;
    logic acc, novf;
    wr_ptr_2_i = gray4(rcnt);
    acc = inc_i && !m_full;
    nw  = m_w + (acc ? 1 : 0);
`ifdef WRITE_PTR_CTRL_SYNC_EN
    rseen = m_s2;
`else
    rseen = rcnt;
`endif
    lvl  = nw - rseen;
    novf = (inc_i && m_full) ? 1'b1 : (clr_ovf_i ? 1'b0 : m_ovf);
    @(posedge clk_i);
    #1;
    m_w     = nw;
    m_level = lvl;
    m_full  = (lvl == 8);
    m_afull = (afull_thresh_i != 0) && (lvl >= int'(afull_thresh_i));
    m_ovf   = novf;
    m_s2    = m_s1;
    m_s1    = rcnt;
  endtask

  task automatic do_reset();
    inc_i = 1'b0; clr_ovf_i = 1'b0; wr_ptr_2_i = '0;
    rst_i = 1'b0;
    model_zero();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    inc_i = 1'b1;
    model_zero();
    #1 rst_i = 1'b0;
    #2;
    n_cmp++; if (ptr_o !== 4'b0) begin n_bad++; $display("FAIL reset_ptr: got %b want 0000", ptr_o); end
    n_cmp++; if (addr_o !== 3'b0) begin n_bad++; $display("FAIL reset_addr: got %b want 000", addr_o); end
    n_cmp++; if (wr_en_o !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en_o); end
    n_cmp++; if ({fifo_full_o, almost_full_o, overflow_o} !== 3'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {fifo_full_o, almost_full_o, overflow_o}); end
    n_cmp++; if (level_o !== 4'b0) begin n_bad++; $display("FAIL reset_level: got %b want 0000", level_o); end
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++; if (ptr_o !== 4'b0 || addr_o !== 3'b0) begin
      n_bad++; $display("FAIL reset_hold: got ptr %b addr %b want 0000 000", ptr_o, addr_o); end
    rst_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++; if (addr_o !== 3'(k)) begin n_bad++; $display("FAIL count_addr%0d: got %0d want %0d", k, addr_o, k); end
      n_cmp++; if (ptr_o !== gray4(k)) begin n_bad++; $display("FAIL count_ptr%0d: got %b want %b", k, ptr_o, gray4(k)); end
    end
    inc_i = 1'b0;
  endtask

  task automatic test_fill();
    do_reset();
    inc_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++; if (fifo_full_o !== (k == 8)) begin
        n_bad++; $display("FAIL fill_full%0d: got %b want %b", k, fifo_full_o, (k == 8)); end
    end
    n_cmp++; if (level_o !== 4'b1000) begin n_bad++; $display("FAIL fill_level: got %b want 1000", level_o); end
    n_cmp++; if (ptr_o !== 4'b1100) begin n_bad++; $display("FAIL fill_ptr: got %b want 1100", ptr_o); end
    n_cmp++; if (addr_o !== 3'b000) begin n_bad++; $display("FAIL fill_addr: got %b want 000", addr_o); end
    #1;
    n_cmp++; if (wr_en_o !== 1'b0) begin n_bad++; $display("FAIL fill_wr_en: got %b want 0", wr_en_o); end
    inc_i = 1'b0;
  endtask

  task automatic test_almost_full();
    do_reset();
    afull_thresh_i = 4'd6;
    inc_i = 1'b1;
    repeat (5) step();
    n_cmp++; if (almost_full_o !== 1'b0) begin n_bad++; $display("FAIL afull_5: got %b want 0", almost_full_o); end
    step();
    n_cmp++; if (almost_full_o !== 1'b1) begin n_bad++; $display("FAIL afull_6: got %b want 1", almost_full_o); end
    do_reset();
    afull_thresh_i = 4'd0;
    inc_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++; if (almost_full_o !== 1'b0) begin n_bad++; $display("FAIL afull_off%0d: got %b want 0", k, almost_full_o); end
    end
    inc_i = 1'b0;
  endtask

  // Continues from the full state left by test_almost_full.
  task automatic test_overflow();
    inc_i = 1'b1; clr_ovf_i = 1'b0;
    step();
    n_cmp++; if (ptr_o !== 4'b1100) begin n_bad++; $display("FAIL ovf_ptr_hold: got %b want 1100", ptr_o); end
    n_cmp++; if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow_o); end
    inc_i = 1'b0; clr_ovf_i = 1'b1;
    step();
    n_cmp++; if (overflow_o !== 1'b0) begin n_bad++; $display("FAIL ovf_clr: got %b want 0", overflow_o); end
    inc_i = 1'b1; clr_ovf_i = 1'b1;
    step();
    n_cmp++; if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL ovf_priority: got %b want 1", overflow_o); end
    inc_i = 1'b0; clr_ovf_i = 1'b0;
  endtask

  // Continues from full with 8 words written; reader takes one word then tracks the writer.
  task automatic test_drain_wrap();
    int lat;
`ifdef WRITE_PTR_CTRL_SYNC_EN
    lat = 3;
`else
    lat = 1;
`endif
    inc_i = 1'b0;
    rcnt = 1;
    for (int i = 1; i <= lat; i++) begin
      step();
      n_cmp++; if (fifo_full_o !== (i < lat)) begin
        n_bad++; $display("FAIL drain_full_e%0d: got %b want %b", i, fifo_full_o, (i < lat)); end
    end
    n_cmp++; if (level_o !== 4'b0111) begin n_bad++; $display("FAIL drain_level: got %b want 0111", level_o); end
    inc_i = 1'b1;
    for (int g = 0; g < 40 && m_w < 16; g++) begin
      rcnt = m_w;
      step();
      n_cmp++; if (fifo_full_o !== 1'b0) begin n_bad++; $display("FAIL wrap_full_w%0d: got %b want 0", m_w, fifo_full_o); end
      n_cmp++; if (ptr_o !== gray4(m_w)) begin n_bad++; $display("FAIL wrap_ptr_w%0d: got %b want %b", m_w, ptr_o, gray4(m_w)); end
    end
    inc_i = 1'b0;
    n_cmp++; if (m_w != 16) begin n_bad++; $display("FAIL wrap_timeout: got %0d writes want 16", m_w); end
    n_cmp++; if (ptr_o !== 4'b0000) begin n_bad++; $display("FAIL wrap_ptr_end: got %b want 0000", ptr_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 0) afull_thresh_i = 4'($urandom_range(0, 8));
      inc_i     = ($urandom_range(0, 3) != 0);
      clr_ovf_i = ($urandom_range(0, 7) == 0);
      if (rcnt < m_w && $urandom_range(0, 4) < 2) rcnt++;
      #1;
      n_cmp++; if (wr_en_o !== (inc_i && !m_full)) begin
        n_bad++; $display("FAIL rnd_wr_en c%0d: got %b want %b", c, wr_en_o, (inc_i && !m_full)); end
      step();
      n_cmp++; if (ptr_o !== gray4(m_w)) begin n_bad++; $display("FAIL rnd_ptr c%0d: got %b want %b", c, ptr_o, gray4(m_w)); end
      n_cmp++; if (addr_o !== 3'(m_w & 7)) begin n_bad++; $display("FAIL rnd_addr c%0d: got %0d want %0d", c, addr_o, m_w & 7); end
      n_cmp++; if (level_o !== 4'(m_level)) begin n_bad++; $display("FAIL rnd_level c%0d: got %0d want %0d", c, level_o, m_level); end
      n_cmp++; if (fifo_full_o !== m_full) begin n_bad++; $display("FAIL rnd_full c%0d: got %b want %b", c, fifo_full_o, m_full); end
      n_cmp++; if (almost_full_o !== m_afull) begin n_bad++; $display("FAIL rnd_afull c%0d: got %b want %b", c, almost_full_o, m_afull); end
      n_cmp++; if (overflow_o !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf c%0d: got %b want %b", c, overflow_o, m_ovf); end
    end
    inc_i = 1'b0; clr_ovf_i = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    afull_thresh_i = 4'd2;
    inc_i = 1'b1;
    repeat (3) step();
    #2 rst_i = 1'b0;
    #1;
    n_cmp++; if ({ptr_o, addr_o, level_o} !== 11'b0) begin
      n_bad++; $display("FAIL async_ptrs: got ptr %b addr %b level %b want 0", ptr_o, addr_o, level_o); end
    n_cmp++; if ({wr_en_o, fifo_full_o, almost_full_o, overflow_o} !== 4'b0) begin
      n_bad++; $display("FAIL async_flags: got %b want 0000", {wr_en_o, fifo_full_o, almost_full_o, overflow_o}); end
    inc_i = 1'b0;
    model_zero();
    @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_almost_full();
    test_overflow();
    test_drain_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
